muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Multi-cycle sequencer for the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) that the ALU decoder selects but cannot complete in one cycle. It sits beside the ALU in the execute stage. It accepts one operation per start pulse and runs an iterative shift-add multiply or restoring divide over the operand magnitudes, applying sign correction afterwards. While it works it holds `busy` so the pipeline controller stalls, and it returns the 32-bit result with a one-cycle `done` pulse.

## Interface
- `XLEN`, 32, operand/result width; iteration count equals `XLEN`
- `clk`  in  1  single clock, rising edge
- `rstN`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only when the block is ready (state IDLE or DONE)
- `flush`  in  1  synchronous abort from the pipeline; priority over `start`
- `opSel`  in  `alu_operation_t`  operation, sampled with `start`
- `operand_a`  in  XLEN  rs1 (multiplicand / dividend), sampled with `start`
- `operand_b`  in  XLEN  rs2 (multiplier / divisor), sampled with `start`
- `ready`  out  1  high in IDLE and DONE
- `busy`  out  1  high in CALC and FIX; stall request
- `done`  out  1  one-cycle pulse; `result` is valid while it is high
- `result`  out  XLEN  registered result; holds its value until the next completion
- `error`  out  `flag_t`  HIGH together with `done` when `opSel` is not an M operation

## Operation
- States:
  - **IDLE**: wait for `start`.
  - **CALC**: XLEN iterations, counter 0..XLEN-1.
  - **FIX**: sign correction, half select and result register load.
  - **DONE**: `done`=1 for exactly one cycle.
- Transitions:
  - IDLE/DONE with `start` and a normal op go to CALC.
  - IDLE/DONE with `start` and a special case go to DONE.
  - CALC at counter XLEN-1 goes to FIX.
  - FIX goes to DONE.
  - DONE without `start` goes to IDLE.
  - `flush` forces IDLE from any state. In that case `done` stays 0 and `result` is unchanged.
- Operand latch:
  - Magnitudes are taken for the signed operands: both for MUL/MULH/DIV/REM, `operand_a` only for MULHSU, none for MULHU/DIVU/REMU.
  - The negate flag is computed as sign(a) XOR sign(b) for the signed quantities.
  - For REM the sign follows the dividend.
- Multiply: 2·XLEN-bit accumulator, shift-add one bit per cycle.
  - MUL returns the low half.
  - MULH/MULHSU/MULHU return the high half of the sign-corrected 2·XLEN product.
- Divide: restoring, one quotient bit per cycle.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
  - Sign correction is applied in FIX.
- Special cases are decided at `start` and skip CALC. The result is loaded directly, with latency 1.
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give `operand_a`.
  - DIV with 0x80000000 / 0xFFFFFFFF gives 0x80000000. REM with the same operands gives 0.
  - Non-M `opSel` gives `result`=0 and `error`=HIGH.
- A `start` while `busy` is ignored and never corrupts the operation in flight.

## Timing
- Reset (rstN=0, asynchronous): state IDLE, counter 0, `busy`=0, `done`=0, `ready`=1, `result`=0, `error`=LOW.
- Normal op, `start` sampled at edge E0:
  - CALC from E0 to E32.
  - FIX from E32 to E33.
  - `done`/`result` valid from E33 to E34.
  - Latency is 33 cycles; `busy` is high for 33 cycles.
- Special case: `done` is high from E0 to E1.
- Back-to-back: `start` during DONE is accepted, so `done` never stays high two cycles for the same op.
- `flush` at edge En mid-operation: IDLE after En, `busy`=0 and `ready`=1 in the next cycle.
- Reset released mid-operation: the block comes up in IDLE and no stale `done` is emitted.

## Structure
- The following belong in the `definitions` package:
  - `muldiv_state_t` (IDLE, CALC, FIX, DONE)
  - `MULDIV_XLEN` = 32
  - an `is_muldiv_op` function over `alu_operation_t`
- `alu_operation_t` and `flag_t` (HIGH/LOW) are reused unchanged.
- One sub-module is natural: `muldiv_step`. It is a combinational single-iteration datapath (shift-add or trial-subtract on the accumulator) instantiated once. The FSM, counter, sign logic and result register stay in `muldiv_seq`.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3): `busy` for 33 cycles, then `done` with 0xFFFFFFEB. MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE.
- MULH 0x80000000 × 0x80000000 gives 0x40000000. MULHSU 0xFFFFFFFF (-1) × 0xFFFFFFFF (unsigned) gives 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 gives 0xFFFFFFFD. REM of the same gives 0xFFFFFFFF. DIVU 100 / 7 gives 14 and REMU gives 2.
- Special cases each produce `done` one cycle after `start` with `busy` never high:
  - DIVU 5 / 0 gives 0xFFFFFFFF.
  - REMU 5 / 0 gives 5.
  - DIV 0x80000000 / 0xFFFFFFFF gives 0x80000000.
- Hazards:
  - `start` with opSel=ADD gives `done`, `error`=HIGH and `result`=0.
  - A second `start` at cycle 5 of a DIV is ignored and the first result is unchanged.
- `flush` at cycle 10 of a MUL: IDLE next cycle, no `done`, previous `result` held.
- rstN low at cycle 20 of a DIV: all outputs reach reset values immediately. After release, a new MUL 3 × 4 gives 12.

Source files
------------

// File: rtl/definitions_pkg.sv
// Shared execute-stage types plus the multiply/divide sequencer state, width
// and op classification helper.
package definitions;

  typedef enum logic [4:0] {
    ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
    MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
  } alu_operation_t;

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } flag_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam int MULDIV_XLEN = 32;

  function automatic logic is_muldiv_op(input alu_operation_t op);
    return op inside {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: shift-add multiply or restoring
// trial-subtract divide on the {hi, lo} accumulator.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o
);

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_shift;
  logic [XLEN-1:0] rem_sub;
  logic            rem_ge;

  always_comb begin
    // multiplier bits sit in the low half and shift out as the product shifts in
    mul_sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
    rem_shift = acc_i[2*XLEN-1:XLEN-1];
    rem_ge    = rem_shift >= {1'b0, opnd_i};
    rem_sub   = rem_shift[XLEN-1:0] - opnd_i;
    if (is_div_i) begin
      acc_o = rem_ge ? {rem_sub, acc_i[XLEN-2:0], 1'b1} : {acc_i[2*XLEN-2:0], 1'b0};
    end else begin
      acc_o = {mul_sum, acc_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer: operand magnitudes are iterated
// XLEN times, then sign-corrected and registered with a one-cycle done pulse.
module muldiv_seq
  import definitions::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            start,
  input  logic            flush,
  input  alu_operation_t  opSel,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output flag_t           error
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_t     state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_step;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   result_q;
  alu_operation_t    op_q;
  logic              neg_q;
  logic              err_q;

  logic            accept;
  logic            in_is_m, in_is_div, in_signed_a, in_signed_b;
  logic            sign_a, sign_b, in_neg;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_res;

  assign accept = start && !flush && (state_q == IDLE || state_q == DONE);

  always_comb begin
    in_is_m     = is_muldiv_op(opSel);
    in_is_div   = opSel inside {DIV, DIVU, REM, REMU};
    in_signed_a = opSel inside {MUL, MULH, MULHSU, DIV, REM};
    in_signed_b = opSel inside {MUL, MULH, DIV, REM};
    sign_a      = in_signed_a && operand_a[XLEN-1];
    sign_b      = in_signed_b && operand_b[XLEN-1];
    mag_a       = sign_a ? -operand_a : operand_a;
    mag_b       = sign_b ? -operand_b : operand_b;
    // remainder sign follows the dividend alone
    in_neg      = (opSel == REM) ? sign_a : (sign_a ^ sign_b);
    div_zero    = in_is_div && (operand_b == '0);
    div_ovf     = (opSel inside {DIV, REM}) && (operand_a == INT_MIN) && (&operand_b);
    special     = !in_is_m || div_zero || div_ovf;
    special_res = '0;
    if (!in_is_m) begin
      special_res = '0;
    end else if (div_zero) begin
      special_res = (opSel inside {DIV, DIVU}) ? '1 : operand_a;
    end else if (div_ovf) begin
      special_res = (opSel == DIV) ? INT_MIN : '0;
    end
  end

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div_i (op_q inside {DIV, DIVU, REM, REMU}),
    .acc_i    (acc_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_step)
  );

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      MUL:                 fix_res = prod_fix[XLEN-1:0];
      MULH, MULHSU, MULHU: fix_res = prod_fix[2*XLEN-1:XLEN];
      DIV, DIVU:           fix_res = quot_fix;
      REM, REMU:           fix_res = rem_fix;
      default:             fix_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = special ? DONE : CALC;
        else       state_d = IDLE;
      end
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_comb begin
    ready  = (state_q == IDLE) || (state_q == DONE);
    busy   = (state_q == CALC) || (state_q == FIX);
    done   = (state_q == DONE);
    result = result_q;
    error  = (state_q == DONE && err_q) ? HIGH : LOW;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      op_q     <= ADD;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (accept) begin
      op_q   <= opSel;
      neg_q  <= in_neg;
      cnt_q  <= '0;
      err_q  <= !in_is_m;
      acc_q  <= in_is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      opnd_q <= in_is_div ? mag_b : mag_a;
      if (special) result_q <= special_res;
    end else if (!flush && state_q == CALC) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (!flush && state_q == FIX) begin
      result_q <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: arithmetic results, special cases, hazards,
// flush and asynchronous reset behaviour.
module tb_muldiv_seq;
  import definitions::*;

  logic           clk = 1'b0;
  logic           rstN, start, flush;
  alu_operation_t opSel;
  logic [31:0]    operand_a, operand_b;
  logic           ready, busy, done;
  logic [31:0]    result;
  flag_t          error;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  muldiv_seq dut (
    .clk(clk), .rstN(rstN), .start(start), .flush(flush), .opSel(opSel),
    .operand_a(operand_a), .operand_b(operand_b), .ready(ready), .busy(busy),
    .done(done), .result(result), .error(error)
  );

  // Issues one start pulse and waits (bounded) for done; returns at the negedge where done is high.
  task automatic run_op(input alu_operation_t op, input logic [31:0] a, input logic [31:0] b,
                        output int busy_cycles, output bit got_done);
    @(negedge clk);
    opSel = op; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0; got_done = 0;
    for (int i = 0; i < 100 && !got_done; i++) begin
      if (done) got_done = 1;
      else begin
        if (busy) busy_cycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; start = 1'b0; flush = 1'b0; opSel = ADD; operand_a = '0; operand_b = '0;
    #2;
    total_cnt++; if (ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL reset_result got %h exp 0", result); else pass_cnt++;
    total_cnt++; if (error !== LOW) $display("FAIL reset_error got %b exp LOW", error); else pass_cnt++;
    @(negedge clk); rstN = 1'b1;
  endtask

  task automatic test_mul();
    int bc; bit gd;
    run_op(MUL, 32'd7, 32'hFFFFFFFD, bc, gd);
    total_cnt++; if (!gd) $display("FAIL mul_done_timeout got 0 exp 1"); else pass_cnt++;
    total_cnt++; if (bc !== 33) $display("FAIL mul_busy_cycles got %0d exp 33", bc); else pass_cnt++;
    total_cnt++; if (result !== 32'hFFFFFFEB) $display("FAIL mul_result got %h exp FFFFFFEB", result); else pass_cnt++;
    total_cnt++; if (error !== LOW) $display("FAIL mul_error got %b exp LOW", error); else pass_cnt++;
    run_op(MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, gd);
    total_cnt++; if (!gd || result !== 32'hFFFFFFFE) $display("FAIL mulhu_result got %h done %b exp FFFFFFFE", result, gd); else pass_cnt++;
    run_op(MULH, 32'h80000000, 32'h80000000, bc, gd);
    total_cnt++; if (!gd || result !== 32'h40000000) $display("FAIL mulh_result got %h done %b exp 40000000", result, gd); else pass_cnt++;
    run_op(MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, gd);
    total_cnt++; if (!gd || result !== 32'hFFFFFFFF) $display("FAIL mulhsu_result got %h done %b exp FFFFFFFF", result, gd); else pass_cnt++;
    run_op(MULH, 32'hFFFFFFFE, 32'd3, bc, gd);
    total_cnt++; if (!gd || result !== 32'hFFFFFFFF) $display("FAIL mulh_neg_result got %h done %b exp FFFFFFFF", result, gd); else pass_cnt++;
  endtask

  task automatic test_div();
    int bc; bit gd;
    run_op(DIV, 32'hFFFFFFF9, 32'd2, bc, gd);
    total_cnt++; if (!gd || result !== 32'hFFFFFFFD) $display("FAIL div_result got %h done %b exp FFFFFFFD", result, gd); else pass_cnt++;
    total_cnt++; if (bc !== 33) $display("FAIL div_busy_cycles got %0d exp 33", bc); else pass_cnt++;
    run_op(REM, 32'hFFFFFFF9, 32'd2, bc, gd);
    total_cnt++; if (!gd || result !== 32'hFFFFFFFF) $display("FAIL rem_result got %h done %b exp FFFFFFFF", result, gd); else pass_cnt++;
    run_op(DIVU, 32'd100, 32'd7, bc, gd);
    total_cnt++; if (!gd || result !== 32'd14) $display("FAIL divu_result got %h done %b exp 0000000e", result, gd); else pass_cnt++;
    run_op(REMU, 32'd100, 32'd7, bc, gd);
    total_cnt++; if (!gd || result !== 32'd2) $display("FAIL remu_result got %h done %b exp 00000002", result, gd); else pass_cnt++;
    run_op(DIV, 32'd100, 32'hFFFFFFF9, bc, gd);
    total_cnt++; if (!gd || result !== 32'hFFFFFFF2) $display("FAIL div_negb_result got %h done %b exp FFFFFFF2", result, gd); else pass_cnt++;
    run_op(DIVU, 32'hFFFFFFFF, 32'h00000001, bc, gd);
    total_cnt++; if (!gd || result !== 32'hFFFFFFFF) $display("FAIL divu_max_result got %h done %b exp FFFFFFFF", result, gd); else pass_cnt++;
  endtask

  task automatic test_special();
    int bc; bit gd;
    run_op(DIVU, 32'd5, 32'd0, bc, gd);
    total_cnt++; if (!gd || bc !== 0 || result !== 32'hFFFFFFFF) $display("FAIL divu_zero got %h busy %0d done %b exp FFFFFFFF busy 0", result, bc, gd); else pass_cnt++;
    run_op(REMU, 32'd5, 32'd0, bc, gd);
    total_cnt++; if (!gd || bc !== 0 || result !== 32'd5) $display("FAIL remu_zero got %h busy %0d done %b exp 00000005 busy 0", result, bc, gd); else pass_cnt++;
    run_op(DIV, 32'h80000000, 32'hFFFFFFFF, bc, gd);
    total_cnt++; if (!gd || bc !== 0 || result !== 32'h80000000) $display("FAIL div_ovf got %h busy %0d done %b exp 80000000 busy 0", result, bc, gd); else pass_cnt++;
    run_op(REM, 32'h80000000, 32'hFFFFFFFF, bc, gd);
    total_cnt++; if (!gd || bc !== 0 || result !== 32'h0) $display("FAIL rem_ovf got %h busy %0d done %b exp 0 busy 0", result, bc, gd); else pass_cnt++;
    total_cnt++; if (error !== LOW) $display("FAIL special_error got %b exp LOW", error); else pass_cnt++;
  endtask

  task automatic test_non_m();
    int bc; bit gd;
    run_op(MUL, 32'd6, 32'd7, bc, gd);
    run_op(ADD, 32'd1, 32'd2, bc, gd);
    total_cnt++; if (!gd || bc !== 0) $display("FAIL nonm_done got done %b busy %0d exp done 1 busy 0", gd, bc); else pass_cnt++;
    total_cnt++; if (error !== HIGH) $display("FAIL nonm_error got %b exp HIGH", error); else pass_cnt++;
    total_cnt++; if (result !== 32'h0) $display("FAIL nonm_result got %h exp 0", result); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0 || error !== LOW) $display("FAIL nonm_pulse got done %b error %b exp 0 LOW", done, error); else pass_cnt++;
  endtask

  task automatic test_start_while_busy();
    int bc; bit gd;
    @(negedge clk);
    opSel = DIV; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    opSel = MUL; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    gd = 0;
    for (int i = 0; i < 100 && !gd; i++) begin
      if (done) gd = 1; else @(negedge clk);
    end
    total_cnt++; if (!gd || result !== 32'd14) $display("FAIL busy_start_result got %h done %b exp 0000000e", result, gd); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0 || ready !== 1'b1) $display("FAIL busy_start_single_done got done %b ready %b exp 0 1", done, ready); else pass_cnt++;
  endtask

  task automatic test_flush();
    bit seen;
    @(negedge clk);
    opSel = MUL; operand_a = 32'd9; operand_b = 32'd9; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    total_cnt++; if (busy !== 1'b0 || ready !== 1'b1) $display("FAIL flush_idle got busy %b ready %b exp 0 1", busy, ready); else pass_cnt++;
    seen = 0;
    repeat (40) begin
      if (done) seen = 1;
      @(negedge clk);
    end
    total_cnt++; if (seen) $display("FAIL flush_no_done got done seen 1 exp 0"); else pass_cnt++;
    total_cnt++; if (result !== 32'd14) $display("FAIL flush_result_held got %h exp 0000000e", result); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bc; bit gd;
    run_op(MUL, 32'd3, 32'd5, bc, gd);
    total_cnt++; if (!gd || result !== 32'd15) $display("FAIL b2b_first got %h done %b exp 0000000f", result, gd); else pass_cnt++;
    opSel = DIVU; operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    total_cnt++; if (done !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_accept got done %b busy %b exp 0 1", done, busy); else pass_cnt++;
    gd = 0;
    for (int i = 0; i < 100 && !gd; i++) begin
      if (done) gd = 1; else @(negedge clk);
    end
    total_cnt++; if (!gd || result !== 32'd14) $display("FAIL b2b_second got %h done %b exp 0000000e", result, gd); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int bc; bit gd, seen;
    @(negedge clk);
    opSel = DIV; operand_a = 32'd1000; operand_b = 32'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    rstN = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0 || ready !== 1'b1 || done !== 1'b0) $display("FAIL rst_mid_ctrl got busy %b ready %b done %b exp 0 1 0", busy, ready, done); else pass_cnt++;
    total_cnt++; if (result !== 32'h0 || error !== LOW) $display("FAIL rst_mid_data got %h error %b exp 0 LOW", result, error); else pass_cnt++;
    @(negedge clk); @(negedge clk);
    rstN = 1'b1;
    seen = 0;
    repeat (40) begin
      if (done || busy) seen = 1;
      @(negedge clk);
    end
    total_cnt++; if (seen) $display("FAIL rst_mid_stale got activity 1 exp 0"); else pass_cnt++;
    run_op(MUL, 32'd3, 32'd4, bc, gd);
    total_cnt++; if (!gd || result !== 32'd12) $display("FAIL rst_mid_mul got %h done %b exp 0000000c", result, gd); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_non_m();
    test_start_while_busy();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
